// File: rtl/plru_set_ctrl.sv
// plru_set_ctrl: owns the per-set pLRU trees and sequences the shared pLRU unit; optional tree flush via `PLRU_CTRL_FLUSH_EN.
// Latency: handshake to resp_valid >= 3 cycles; req_ready low while a request/flush is in flight, ISSUE holds while plru_busy.
module plru_set_ctrl #(
  parameter int SETWAY   = 4,
  parameter int NUM_SETS = 64,
  localparam int BITS_SETWAY = $clog2(SETWAY),
  localparam int SET_W       = $clog2(NUM_SETS),
  localparam int TREE_W      = SETWAY - 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [SET_W-1:0]       i_req_set,
  input  logic                   i_req_hit,
  input  logic [BITS_SETWAY-1:0] i_req_way,
  output logic                   o_resp_valid,
  output logic [SET_W-1:0]       o_resp_set,
  output logic [BITS_SETWAY-1:0] o_resp_way,
  output logic [BITS_SETWAY-1:0] o_plru_line_num,
  output logic [TREE_W-1:0]      o_plru_bTree_in,
  output logic                   o_plru_hit,
  output logic                   o_plru_miss,
  output logic [BITS_SETWAY:0]   o_plru_linesInSet,
  input  logic [TREE_W-1:0]      i_plru_bTree_out,
  input  logic                   i_plru_bTree_valid,
  input  logic [BITS_SETWAY-1:0] i_plru_index_out,
  input  logic                   i_plru_busy,
  input  logic                   i_flush_req,
  output logic                   o_flush_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
`ifdef PLRU_CTRL_FLUSH_EN
    , ST_FLUSH
`endif
  } state_t;

  typedef struct packed {
    logic [SET_W-1:0]       set;
    logic                   hit;
    logic [BITS_SETWAY-1:0] way;
  } req_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  req_t                   r_req;
  logic [SET_W-1:0]       r_resp_set;
  logic [BITS_SETWAY-1:0] r_resp_way;
  logic [TREE_W-1:0]      r_tree [NUM_SETS];

  logic w_accept;
  logic w_issue;
  logic w_wb;
  logic w_flush_start;
  logic w_unused;

  // ---------------- state register ----------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef PLRU_CTRL_FLUSH_EN
  logic [SET_W-1:0] r_flush_idx;
  logic             r_flush_done;
  logic             w_flush_last;

  assign w_flush_start = (r_state == ST_IDLE) && i_flush_req;
  assign w_flush_last  = (r_state == ST_FLUSH) && (r_flush_idx == SET_W'(NUM_SETS - 1));
`else
  assign w_flush_start = 1'b0;
`endif

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_flush_start) begin
`ifdef PLRU_CTRL_FLUSH_EN
          w_state_nxt = ST_FLUSH;
`endif
        end else if (i_req_valid) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (!i_plru_busy)       w_state_nxt = ST_WAIT;
      ST_WAIT:  if (i_plru_bTree_valid) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
`ifdef PLRU_CTRL_FLUSH_EN
      ST_FLUSH: if (w_flush_last)       w_state_nxt = ST_IDLE;
`endif
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    o_req_ready     = (r_state == ST_IDLE) && !w_flush_start;
    w_issue         = (r_state == ST_ISSUE) && !i_plru_busy;
    w_wb            = (r_state == ST_WAIT) && i_plru_bTree_valid;
    o_plru_hit      = w_issue && r_req.hit;
    o_plru_miss     = w_issue && !r_req.hit;
    o_plru_line_num = (w_issue && r_req.hit) ? r_req.way : '0;
    o_plru_bTree_in = w_issue ? r_tree[r_req.set] : '0;
    o_resp_valid    = (r_state == ST_RESP);
  end

  assign w_accept          = i_req_valid && o_req_ready;
  assign o_resp_set        = r_resp_set;
  assign o_resp_way        = r_resp_way;
  assign o_plru_linesInSet = (BITS_SETWAY + 1)'(SETWAY);

  // ---------------- request / response registers ----------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_req      <= '0;
      r_resp_set <= '0;
      r_resp_way <= '0;
    end else begin
      if (w_accept) begin
        r_req.set <= i_req_set;
        r_req.hit <= i_req_hit;
        r_req.way <= i_req_way;
      end
      if (w_wb) begin
        r_resp_set <= r_req.set;
        r_resp_way <= r_req.hit ? r_req.way : i_plru_index_out;
      end
    end
  end

  // Single outstanding request, so the ISSUE-cycle read and the WAIT write-back never collide.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int s = 0; s < NUM_SETS; s++) r_tree[s] <= '0;
    end else begin
      if (w_wb) r_tree[r_req.set] <= i_plru_bTree_out;
`ifdef PLRU_CTRL_FLUSH_EN
      if (r_state == ST_FLUSH) r_tree[r_flush_idx] <= '0;
`endif
    end
  end

`ifdef PLRU_CTRL_FLUSH_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_flush_idx  <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= w_flush_last;
      if (r_state == ST_FLUSH)
        r_flush_idx <= w_flush_last ? '0 : r_flush_idx + 1'b1;
    end
  end

  assign o_flush_done = r_flush_done;
  assign w_unused     = 1'b0;
`else
  assign o_flush_done = 1'b0;
  assign w_unused     = i_flush_req;
`endif

  // ---------------- protocol checks ----------------
  a_hit_miss_excl: assert property (@(posedge i_clk) disable iff (!i_rst)
    !(o_plru_hit && o_plru_miss));
  a_resp_pulse: assert property (@(posedge i_clk) disable iff (!i_rst)
    o_resp_valid |=> !o_resp_valid);
  a_issue_once: assert property (@(posedge i_clk) disable iff (!i_rst)
    (o_plru_hit || o_plru_miss) |=> !(o_plru_hit || o_plru_miss));

endmodule

// File: tb/tb_plru_set_ctrl.sv
// Directed bench for plru_set_ctrl: the shared pLRU unit is stubbed by hand-driven bTree/index/busy inputs.
module tb_plru_set_ctrl;

  logic       i_clk;
  logic       i_rst;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [5:0] i_req_set;
  logic       i_req_hit;
  logic [1:0] i_req_way;
  logic       o_resp_valid;
  logic [5:0] o_resp_set;
  logic [1:0] o_resp_way;
  logic [1:0] o_plru_line_num;
  logic [2:0] o_plru_bTree_in;
  logic       o_plru_hit;
  logic       o_plru_miss;
  logic [2:0] o_plru_linesInSet;
  logic [2:0] i_plru_bTree_out;
  logic       i_plru_bTree_valid;
  logic [1:0] i_plru_index_out;
  logic       i_plru_busy;
  logic       i_flush_req;
  logic       o_flush_done;

  int n_cmp = 0;
  int n_err = 0;

  plru_set_ctrl u_dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_req_set          (i_req_set),
    .i_req_hit          (i_req_hit),
    .i_req_way          (i_req_way),
    .o_resp_valid       (o_resp_valid),
    .o_resp_set         (o_resp_set),
    .o_resp_way         (o_resp_way),
    .o_plru_line_num    (o_plru_line_num),
    .o_plru_bTree_in    (o_plru_bTree_in),
    .o_plru_hit         (o_plru_hit),
    .o_plru_miss        (o_plru_miss),
    .o_plru_linesInSet  (o_plru_linesInSet),
    .i_plru_bTree_out   (i_plru_bTree_out),
    .i_plru_bTree_valid (i_plru_bTree_valid),
    .i_plru_index_out   (i_plru_index_out),
    .i_plru_busy        (i_plru_busy),
    .i_flush_req        (i_flush_req),
    .o_flush_done       (o_flush_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // One full request; the caller supplies every expected value.
  task automatic run_req(input string tag, input logic [5:0] set, input logic hit,
                         input logic [1:0] way, input int busy, input logic [2:0] exp_tin,
                         input logic [2:0] tout, input logic [1:0] idx, input int dly,
                         input logic [1:0] exp_line, input logic [1:0] exp_way);
    i_req_valid = 1'b1;
    i_req_set   = set;
    i_req_hit   = hit;
    i_req_way   = way;
    i_plru_busy = (busy > 0);
    #1 chk({tag, ".ready_idle"}, 32'(o_req_ready), 32'(1));
    step();
    i_req_valid = 1'b0;
    for (int i = 0; i < busy; i++) begin
      #1;
      chk({tag, ".busy_hit"},   32'(o_plru_hit),  32'(0));
      chk({tag, ".busy_miss"},  32'(o_plru_miss), 32'(0));
      chk({tag, ".busy_ready"}, 32'(o_req_ready), 32'(0));
      step();
    end
    i_plru_busy = 1'b0;
    #1;
    chk({tag, ".issue_hit"},  32'(o_plru_hit),      32'(hit));
    chk({tag, ".issue_miss"}, 32'(o_plru_miss),     32'(!hit));
    chk({tag, ".issue_line"}, 32'(o_plru_line_num), 32'(exp_line));
    chk({tag, ".issue_tree"}, 32'(o_plru_bTree_in), 32'(exp_tin));
    chk({tag, ".issue_rdy"},  32'(o_req_ready),     32'(0));
    step();
    chk({tag, ".wait_hit"},  32'(o_plru_hit),  32'(0));
    chk({tag, ".wait_miss"}, 32'(o_plru_miss), 32'(0));
    for (int i = 0; i < dly; i++) begin
      chk({tag, ".wait_resp"}, 32'(o_resp_valid), 32'(0));
      step();
    end
    i_plru_bTree_valid = 1'b1;
    i_plru_bTree_out   = tout;
    i_plru_index_out   = idx;
    step();
    i_plru_bTree_valid = 1'b0;
    chk({tag, ".resp_vld"}, 32'(o_resp_valid), 32'(1));
    chk({tag, ".resp_set"}, 32'(o_resp_set),   32'(set));
    chk({tag, ".resp_way"}, 32'(o_resp_way),   32'(exp_way));
    chk({tag, ".resp_rdy"}, 32'(o_req_ready),  32'(0));
    step();
    chk({tag, ".post_vld"}, 32'(o_resp_valid), 32'(0));
    chk({tag, ".post_rdy"}, 32'(o_req_ready),  32'(1));
    chk({tag, ".post_way"}, 32'(o_resp_way),   32'(exp_way));
  endtask

  initial begin
    i_rst = 1'b0;
    i_req_valid = 1'b0; i_req_set = '0; i_req_hit = 1'b0; i_req_way = '0;
    i_plru_bTree_out = '0; i_plru_bTree_valid = 1'b0; i_plru_index_out = '0;
    i_plru_busy = 1'b0; i_flush_req = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    chk("rst.resp_vld",  32'(o_resp_valid),      32'(0));
    chk("rst.hit",       32'(o_plru_hit),        32'(0));
    chk("rst.miss",      32'(o_plru_miss),       32'(0));
    chk("rst.flush_done",32'(o_flush_done),      32'(0));
    chk("rst.resp_set",  32'(o_resp_set),        32'(0));
    chk("rst.resp_way",  32'(o_resp_way),        32'(0));
    chk("rst.line",      32'(o_plru_line_num),   32'(0));
    chk("rst.tree",      32'(o_plru_bTree_in),   32'(0));
    chk("rst.lines",     32'(o_plru_linesInSet), 32'(4));
    i_rst = 1'b1;
    step();
    chk("rel.ready", 32'(o_req_ready), 32'(1));

    //        tag    set  hit way busy tin     tout    idx  dly line way
    run_req("m7",   7,   0,  0,  0,  3'b000, 3'b011, 2'd0, 0, 0, 0);
    run_req("m5",   5,   0,  3,  0,  3'b000, 3'b101, 2'd2, 1, 0, 2);
    run_req("h5",   5,   1,  0,  0,  3'b101, 3'b100, 2'd3, 0, 0, 0);
    run_req("m4",   4,   0,  0,  0,  3'b000, 3'b001, 2'd1, 2, 0, 1);
    run_req("h3",   3,   1,  1,  0,  3'b000, 3'b010, 2'd0, 0, 1, 1);
    run_req("h3b",  3,   1,  2,  0,  3'b010, 3'b110, 2'd1, 0, 2, 2);
    run_req("bsy",  10,  0,  0,  4,  3'b000, 3'b111, 2'd3, 0, 0, 3);

    // Stray bTree_valid in IDLE must not produce a response.
    i_plru_bTree_valid = 1'b1;
    i_plru_bTree_out   = 3'b111;
    step();
    i_plru_bTree_valid = 1'b0;
    chk("stray.resp_vld", 32'(o_resp_valid), 32'(0));
    chk("stray.ready",    32'(o_req_ready),  32'(1));

    // Async reset in the middle of WAIT on set 9.
    i_req_valid = 1'b1; i_req_set = 6'd9; i_req_hit = 1'b0; i_req_way = '0;
    step();
    i_req_valid = 1'b0;
    step();
    i_plru_bTree_valid = 1'b1;
    i_plru_bTree_out   = 3'b111;
    i_plru_index_out   = 2'd1;
    #2 i_rst = 1'b0;
    #1;
    chk("arst.resp_vld", 32'(o_resp_valid), 32'(0));
    chk("arst.resp_set", 32'(o_resp_set),   32'(0));
    step();
    i_plru_bTree_valid = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    chk("arst.after_vld", 32'(o_resp_valid), 32'(0));
    run_req("m9",   9,   0,  0,  0,  3'b000, 3'b001, 2'd2, 0, 0, 2);
    run_req("m5r",  5,   0,  0,  0,  3'b000, 3'b011, 2'd1, 0, 0, 1);

`ifdef PLRU_CTRL_FLUSH_EN
    run_req("p0",   0,   0,  0,  0,  3'b000, 3'b111, 2'd3, 0, 0, 3);
    run_req("p63",  63,  0,  0,  0,  3'b000, 3'b101, 2'd2, 0, 0, 2);
    i_flush_req = 1'b1;
    i_req_valid = 1'b1; i_req_set = 6'd0; i_req_hit = 1'b0;
    #1 chk("fl.ready_blocked", 32'(o_req_ready), 32'(0));
    step();
    i_flush_req = 1'b0;
    i_req_valid = 1'b0;
    #1;
    chk("fl.no_issue", 32'(o_plru_miss), 32'(0));
    begin
      int cyc;
      cyc = 0;
      // 64 clearing cycles after the sampling edge, done visible in the following cycle.
      while (!o_flush_done && cyc < 200) begin
        chk("fl.ready_low", 32'(o_req_ready), 32'(0));
        step();
        cyc++;
      end
      chk("fl.done_cycles", 32'(cyc), 32'(64));
    end
    step();
    chk("fl.done_pulse", 32'(o_flush_done), 32'(0));
    run_req("f0",   0,   0,  0,  0,  3'b000, 3'b001, 2'd0, 0, 0, 0);
    run_req("f63",  63,  0,  0,  0,  3'b000, 3'b001, 2'd0, 0, 0, 0);
`else
    i_flush_req = 1'b1;
    #1 chk("nofl.ready", 32'(o_req_ready), 32'(1));
    step();
    i_flush_req = 1'b0;
    chk("nofl.done",  32'(o_flush_done), 32'(0));
    chk("nofl.ready2",32'(o_req_ready),  32'(1));
    run_req("nf5",  5,   0,  0,  0,  3'b011, 3'b000, 2'd1, 0, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule
